// File: rtl/cpu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// cpu_muldiv_unit
//
// Iterative RV32M multiply/divide unit for the execute stage. One operation is
// accepted at a time through a valid/ready handshake, computed over several
// cycles on operand magnitudes, sign-corrected, then held until consumed.
//
// Parameters
//   XLEN      operand/result width (even, >= 8)
//   DIV_STEP  quotient bits per divide cycle (1, 2 or 4; divides XLEN)
//   MUL_STEP  multiplier bits per multiply cycle (1, 2 or 4; divides XLEN)
//
// Ports
//   clk         core clock, rising edge
//   clr_n       asynchronous active-low reset
//   flush       synchronous abort of any in-flight or held operation
//   in_valid    operation request
//   in_ready    unit can accept a request (IDLE only)
//   in_funct    RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   in_src_a    rs1 value, sampled on the accept edge only
//   in_src_b    rs2 value, sampled on the accept edge only
//   out_valid   result available (DONE)
//   out_ready   consumer takes the result
//   out_result  result, stable while out_valid is high
//   busy        high whenever the unit is not IDLE
// -----------------------------------------------------------------------------
module cpu_muldiv_unit #(
   parameter int XLEN     = 32,
   parameter int DIV_STEP = 1,
   parameter int MUL_STEP = 1
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_funct,
   input  logic [XLEN-1:0] in_src_a,
   input  logic [XLEN-1:0] in_src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            busy
);

   localparam int              CW       = $clog2(XLEN);
   localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_STEP - 1);
   localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN / DIV_STEP - 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t            state;
   logic [2:0]        funct_q;
   logic              neg_q;      // result needs negation in FIX
   logic [2*XLEN-1:0] acc;        // mul: {partial hi, multiplier}; div: {remainder, quotient}
   logic [XLEN-1:0]   opnd;       // mul: multiplicand magnitude; div: divisor magnitude
   logic [XLEN-1:0]   result_q;
   logic [CW-1:0]     cnt;

   // ---------------------------------------------------------------------------
   // Accept-time decode: signedness, magnitudes and divide special cases.
   // ---------------------------------------------------------------------------
   logic              is_div_in;
   logic              a_signed, b_signed, sign_a, sign_b, neg_in;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   mag_a, mag_b, special_res, init_opnd;
   logic [2*XLEN-1:0] init_acc;

   // NOTE: every signal driven here gets a value on every path, so no latch is
   // inferred; the plain assignments below cover all of them up front.
   always_comb begin
      is_div_in = in_funct[2];
      a_signed  = is_div_in ? ~in_funct[0] : (in_funct != 3'b011);
      b_signed  = is_div_in ? ~in_funct[0] : ~in_funct[1];
      sign_a    = a_signed & in_src_a[XLEN-1];
      sign_b    = b_signed & in_src_b[XLEN-1];
      mag_a     = sign_a ? -in_src_a : in_src_a;
      mag_b     = sign_b ? -in_src_b : in_src_b;
      // Remainder follows the dividend; everything else follows sign xor.
      neg_in    = (is_div_in && in_funct[1]) ? sign_a : (sign_a ^ sign_b);

      div_zero  = (in_src_b == '0);
      div_ovf   = ~in_funct[0] && (in_src_a == MOST_NEG) && (in_src_b == '1);
      special   = is_div_in && (div_zero || div_ovf);
      if (div_zero) special_res = in_funct[1] ? in_src_a : '1;
      else          special_res = in_funct[1] ? '0 : in_src_a;

      init_acc  = is_div_in ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      init_opnd = is_div_in ? mag_b : mag_a;
   end

   // ---------------------------------------------------------------------------
   // Single step datapath. In IDLE it works on the freshly decoded operands so
   // step 0 happens on the accept edge; in CALC it works on the held state.
   // ---------------------------------------------------------------------------
   logic                     step_div;
   logic [2*XLEN-1:0]        step_acc, mul_next, div_next, step_next;
   logic [XLEN-1:0]          step_opnd, rem_t, quo_t;
   logic [XLEN+MUL_STEP-1:0] pp, mul_sum;
   logic [XLEN:0]            trial, diff;

   always_comb begin
      step_div  = (state == S_IDLE) ? in_funct[2] : funct_q[2];
      step_acc  = (state == S_IDLE) ? init_acc    : acc;
      step_opnd = (state == S_IDLE) ? init_opnd   : opnd;

      // Shift-add: add multiplicand * low MUL_STEP multiplier bits into the
      // upper half, then shift the whole product right by MUL_STEP.
      pp       = {{MUL_STEP{1'b0}}, step_opnd} * {{XLEN{1'b0}}, step_acc[MUL_STEP-1:0]};
      mul_sum  = {{MUL_STEP{1'b0}}, step_acc[2*XLEN-1:XLEN]} + pp;
      mul_next = {mul_sum, step_acc[XLEN-1:MUL_STEP]};

      // Restoring division, DIV_STEP quotient bits per cycle.
      rem_t = step_acc[2*XLEN-1:XLEN];
      quo_t = step_acc[XLEN-1:0];
      trial = '0;
      diff  = '0;
      for (int i = 0; i < DIV_STEP; i++) begin
         trial = {rem_t, quo_t[XLEN-1]};
         quo_t = {quo_t[XLEN-2:0], 1'b0};
         diff  = trial - {1'b0, step_opnd};
         if (!diff[XLEN]) begin
            rem_t    = diff[XLEN-1:0];
            quo_t[0] = 1'b1;
         end else begin
            rem_t = trial[XLEN-1:0];
         end
      end
      div_next = {rem_t, quo_t};

      step_next = step_div ? div_next : mul_next;
   end

   // ---------------------------------------------------------------------------
   // Sign correction and result selection for FIX.
   // ---------------------------------------------------------------------------
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (funct_q[2])                fix_res = funct_q[1] ? rem_fix : quo_fix;
      else if (funct_q[1:0] == 2'b00) fix_res = prod_fix[XLEN-1:0];
      else                           fix_res = prod_fix[2*XLEN-1:XLEN];
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered handshake outputs.
   // ---------------------------------------------------------------------------
   // NOTE: datapath registers are reset along with control so a reset leaves
   // no stale operand or result visible on out_result.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= S_IDLE;
         funct_q   <= '0;
         neg_q     <= 1'b0;
         acc       <= '0;
         opnd      <= '0;
         result_q  <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (flush) begin
         // NOTE: state updates use non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         state     <= S_IDLE;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  funct_q  <= in_funct;
                  neg_q    <= neg_in;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (special) begin
                     result_q  <= special_res;
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     acc   <= step_next;
                     opnd  <= init_opnd;
                     cnt   <= CW'(1);
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc <= step_next;
               cnt <= cnt + 1'b1;
               if (cnt == (funct_q[2] ? DIV_LAST : MUL_LAST)) state <= S_FIX;
            end
            S_FIX: begin
               result_q  <= fix_res;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign out_result = result_q;

endmodule

// File: tb/tb_cpu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_cpu_muldiv_unit
//
// Directed and randomized checks of cpu_muldiv_unit at the default geometry
// (XLEN=32, DIV_STEP=1, MUL_STEP=1) and at XLEN=16, DIV_STEP=4, MUL_STEP=2.
// Expected results come from a plain-arithmetic RV32M reference model.
// -----------------------------------------------------------------------------
module tb_cpu_muldiv_unit;

   logic        clk = 1'b0;
   logic        clr_n;

   logic        flush, in_valid, out_ready;
   logic [2:0]  in_funct;
   logic [31:0] in_src_a, in_src_b;
   logic        in_ready, out_valid, busy;
   logic [31:0] out_result;

   logic        flush_h, in_valid_h, out_ready_h;
   logic [2:0]  in_funct_h;
   logic [15:0] in_src_a_h, in_src_b_h;
   logic        in_ready_h, out_valid_h, busy_h;
   logic [15:0] out_result_h;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cpu_muldiv_unit dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_funct   (in_funct),
      .in_src_a   (in_src_a),
      .in_src_b   (in_src_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .busy       (busy)
   );

   cpu_muldiv_unit #(.XLEN(16), .DIV_STEP(4), .MUL_STEP(2)) dut_h (
      .clk        (clk),
      .clr_n      (clr_n),
      .flush      (flush_h),
      .in_valid   (in_valid_h),
      .in_ready   (in_ready_h),
      .in_funct   (in_funct_h),
      .in_src_a   (in_src_a_h),
      .in_src_b   (in_src_b_h),
      .out_valid  (out_valid_h),
      .out_ready  (out_ready_h),
      .out_result (out_result_h),
      .busy       (busy_h)
   );

   // RV32M semantics on xl-bit operands using 64-bit integer arithmetic.
   function automatic logic [31:0] ref_model(input int xl, input logic [2:0] f,
                                             input logic [31:0] a, input logic [31:0] b);
      longint mask, ua, ub, sa, sb, min_v, r;
      logic   ovf;
      mask  = (longint'(1) <<< xl) - 1;
      ua    = longint'(a) & mask;
      ub    = longint'(b) & mask;
      sa    = a[xl-1] ? ua - (longint'(1) <<< xl) : ua;
      sb    = b[xl-1] ? ub - (longint'(1) <<< xl) : ub;
      min_v = -(longint'(1) <<< (xl - 1));
      ovf   = (sa == min_v) && (sb == -1);
      case (f)
         3'd0, 3'd1: r = sa * sb;
         3'd2:       r = sa * ub;
         3'd3:       r = ua * ub;
         3'd4:       r = (ub == 0) ? -1 : (ovf ? sa : sa / sb);
         3'd5:       r = (ub == 0) ? -1 : ua / ub;
         3'd6:       r = (ub == 0) ? sa : (ovf ? 0 : sa % sb);
         default:    r = (ub == 0) ? ua : ua % ub;
      endcase
      if (f == 3'd1 || f == 3'd2 || f == 3'd3) r = r >>> xl;
      return 32'(r & mask);
   endfunction

   function automatic int exp_latency(input int xl, input int ms, input int ds,
                                      input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      logic [31:0] mask, min_v;
      mask  = (xl == 32) ? 32'hFFFF_FFFF : ((32'd1 << xl) - 1);
      min_v = 32'd1 << (xl - 1);
      if (f[2] && (((b & mask) == 0) ||
                   (!f[0] && (a & mask) == min_v && (b & mask) == mask)))
         return 1;
      return f[2] ? xl / ds + 1 : xl / ms + 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic consume32();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
   endtask

   // Issue one operation to the 32-bit unit (called at a negedge) and wait for
   // its result, checking handshake behaviour and latency on the way.
   task automatic op32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input bit consume, input string tag,
                       output logic [31:0] res);
      int   lat;
      logic busy_all, ready_seen;
      lat = 0;
      while (!in_ready && lat < 100) begin @(negedge clk); lat++; end
      check({tag, " accept ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_funct = f; in_src_a = a; in_src_b = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_funct = 3'($urandom); in_src_a = $urandom; in_src_b = $urandom;
      lat = 0; busy_all = 1'b1; ready_seen = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         busy_all   = busy_all & busy;
         ready_seen = ready_seen | in_ready;
      end while (!out_valid && lat < 200);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " busy"}, 32'(busy_all), 32'd1);
      check({tag, " in_ready low"}, 32'(ready_seen), 32'd0);
      res = out_result;
      if (consume) consume32();
   endtask

   task automatic op16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                       input int exp_lat, input string tag, output logic [15:0] res);
      int lat;
      lat = 0;
      while (!in_ready_h && lat < 100) begin @(negedge clk); lat++; end
      check({tag, " accept ready"}, 32'(in_ready_h), 32'd1);
      in_valid_h = 1'b1; in_funct_h = f; in_src_a_h = a; in_src_b_h = b;
      @(posedge clk);
      #1;
      in_valid_h = 1'b0;
      in_funct_h = 3'($urandom); in_src_a_h = 16'($urandom); in_src_b_h = 16'($urandom);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!out_valid_h && lat < 200);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      res = out_result_h;
      out_ready_h = 1'b1;
      @(posedge clk);
      #1 out_ready_h = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] r, a, b, hold_v;
      logic [15:0] rh, ah, bh;
      logic [2:0]  f;
      logic        stable, rdy, seen;
      int          sel;

      clr_n = 1'b0;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_funct = '0; in_src_a = '0; in_src_b = '0;
      flush_h = 1'b0; in_valid_h = 1'b0; out_ready_h = 1'b0;
      in_funct_h = '0; in_src_a_h = '0; in_src_b_h = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_result", out_result, 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset16 in_ready", 32'(in_ready_h), 32'd1);
      check("reset16 busy", 32'(busy_h), 32'd0);
      clr_n = 1'b1;
      @(negedge clk);

      // Multiply family.
      op32(3'b000, 32'd7, 32'hFFFF_FFFD, 33, 1'b1, "mul 7*-3", r);
      check("mul 7*-3 result", r, 32'hFFFF_FFEB);
      op32(3'b001, 32'h8000_0000, 32'h8000_0000, 33, 1'b1, "mulh", r);
      check("mulh result", r, 32'h4000_0000);
      op32(3'b010, 32'h8000_0000, 32'h8000_0000, 33, 1'b1, "mulhsu", r);
      check("mulhsu result", r, 32'hC000_0000);
      op32(3'b011, 32'h8000_0000, 32'h8000_0000, 33, 1'b1, "mulhu", r);
      check("mulhu result", r, 32'h4000_0000);

      // Divide family.
      op32(3'b100, 32'hFFFF_FFF9, 32'd2, 33, 1'b1, "div -7/2", r);
      check("div -7/2 result", r, 32'hFFFF_FFFD);
      op32(3'b110, 32'hFFFF_FFF9, 32'd2, 33, 1'b1, "rem -7%2", r);
      check("rem -7%2 result", r, 32'hFFFF_FFFF);
      op32(3'b101, 32'd100, 32'd7, 33, 1'b1, "divu 100/7", r);
      check("divu 100/7 result", r, 32'd14);

      // Divide special cases.
      op32(3'b101, 32'd5, 32'd0, 1, 1'b1, "divu by 0", r);
      check("divu by 0 result", r, 32'hFFFF_FFFF);
      op32(3'b110, 32'd5, 32'd0, 1, 1'b1, "rem by 0", r);
      check("rem by 0 result", r, 32'd5);
      op32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b1, "div ovf", r);
      check("div ovf result", r, 32'h8000_0000);
      op32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b1, "rem ovf", r);
      check("rem ovf result", r, 32'd0);

      // Result held while the consumer stalls.
      op32(3'b101, 32'd100, 32'd7, 33, 1'b0, "hold", hold_v);
      stable = 1'b1; rdy = 1'b0;
      repeat (10) begin
         @(negedge clk);
         stable = stable & out_valid & (out_result == hold_v);
         rdy    = rdy | in_ready;
      end
      check("hold result stable", 32'(stable), 32'd1);
      check("hold in_ready low", 32'(rdy), 32'd0);
      check("hold value", hold_v, 32'd14);
      consume32();
      check("after consume out_valid", 32'(out_valid), 32'd0);
      check("after consume in_ready", 32'(in_ready), 32'd1);

      // Flush in CALC at step 10, with a competing request that must be dropped.
      in_valid = 1'b1; in_funct = 3'b000; in_src_a = 32'd3; in_src_b = 32'd5;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("pre-flush busy", 32'(busy), 32'd1);
      flush = 1'b1; in_valid = 1'b1; in_funct = 3'b101; in_src_b = 32'd0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush calc busy", 32'(busy), 32'd0);
      check("flush calc in_ready", 32'(in_ready), 32'd1);
      check("flush calc out_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      repeat (40) begin @(negedge clk); seen = seen | out_valid | busy; end
      check("flush calc no result", 32'(seen), 32'd0);

      // Flush in IDLE beats a simultaneous request.
      flush = 1'b1; in_valid = 1'b1; in_funct = 3'b101; in_src_a = 32'd9; in_src_b = 32'd0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush idle no accept", 32'(busy | out_valid), 32'd0);

      // Flush in DONE beats out_ready.
      op32(3'b100, 32'd40, 32'd3, 33, 1'b0, "pre-flush done", r);
      check("pre-flush done result", r, 32'd13);
      flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; out_ready = 1'b0;
      check("flush done out_valid", 32'(out_valid), 32'd0);
      check("flush done in_ready", 32'(in_ready), 32'd1);

      // Asynchronous reset in the middle of a divide.
      in_valid = 1'b1; in_funct = 3'b100; in_src_a = 32'd1000; in_src_b = 32'd3;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 clr_n = 1'b0;
      #1;
      check("midreset in_ready", 32'(in_ready), 32'd1);
      check("midreset out_valid", 32'(out_valid), 32'd0);
      check("midreset out_result", out_result, 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);

      // Randomized operations at the default geometry.
      for (int i = 0; i < 24; i++) begin
         f   = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if (sel == 2) b = 32'($urandom_range(1, 15));
         op32(f, a, b, exp_latency(32, 1, 1, f, a, b), 1'b1,
              $sformatf("rand32 f%0d", f), r);
         check($sformatf("rand32 f%0d a=%h b=%h", f, a, b), r, ref_model(32, f, a, b));
      end

      // Parameter sweep: XLEN=16, DIV_STEP=4, MUL_STEP=2.
      op16(3'b100, 16'hFFF9, 16'd2, 5, "div16 -7/2", rh);
      check("div16 -7/2 result", 32'(rh), 32'h0000_FFFD);
      op16(3'b000, 16'd7, 16'hFFFD, 9, "mul16 7*-3", rh);
      check("mul16 7*-3 result", 32'(rh), 32'h0000_FFEB);
      for (int i = 0; i < 40; i++) begin
         f   = 3'($urandom_range(0, 7));
         ah  = 16'($urandom);
         bh  = 16'($urandom);
         sel = $urandom_range(0, 7);
         if (sel == 0) bh = 16'd0;
         if (sel == 1) begin ah = 16'h8000; bh = 16'hFFFF; end
         if (sel == 2) bh = 16'($urandom_range(1, 15));
         op16(f, ah, bh, exp_latency(16, 2, 4, f, 32'(ah), 32'(bh)),
              $sformatf("rand16 f%0d", f), rh);
         check($sformatf("rand16 f%0d a=%h b=%h", f, ah, bh), 32'(rh),
               ref_model(16, f, 32'(ah), 32'(bh)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
